// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-to-APB sequencer: FSM state encoding,
// AHB transfer/response encodings and the default peripheral address map.
package ahb_apb_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h8000_0000;
  localparam int          DEFAULT_REGION_LOG2 = 26;
  localparam int          NUM_SLAVES          = 3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_WRITE,
    ST_WENABLE,
    ST_READ,
    ST_RENABLE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are never acted on.
  function automatic logic is_active_trans(input logic [1:0] htrans);
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
      default:                   return 1'b0;
    endcase
  endfunction

  // States in which hreadyout is high, so a new address phase may be accepted.
  function automatic logic is_dispatch(input state_e s);
    return (s == ST_IDLE) || (s == ST_WENABLE) || (s == ST_RENABLE) || (s == ST_ERR2);
  endfunction

endpackage

// File: rtl/ahb_apb_controller_if.sv
// Bus bundle between the AHB master/decoder, the sequencer and the APB stage.
interface ahb_apb_controller_if;
  import ahb_apb_pkg::*;

  // AHB side
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  // APB stage side
  logic [31:0]           prdata;
  logic                  pwrite;
  logic                  penable;
  logic [NUM_SLAVES-1:0] pselx;
  logic [31:0]           paddr;
  logic [31:0]           pwdata;

  // Environment view: drives the AHB request and the APB read data.
  modport master (
    output hwrite, hreadyin, htrans, haddr, hwdata, prdata,
    input  hreadyout, hresp, hrdata, pwrite, penable, pselx, paddr, pwdata
  );

  // Sequencer view.
  modport slave (
    input  hwrite, hreadyin, htrans, haddr, hwdata, prdata,
    output hreadyout, hresp, hrdata, pwrite, penable, pselx, paddr, pwdata
  );

endinterface

// File: rtl/ahb_apb_decode.sv
// Combinational address decoder: maps haddr onto one of three equally sized,
// contiguous peripheral regions starting at BASE_ADDR.
module ahb_apb_decode
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          REGION_LOG2 = DEFAULT_REGION_LOG2
) (
  input  logic [31:0]           haddr_i,
  output logic [NUM_SLAVES-1:0] hit_o,
  output logic                  mapped_o
);

  // Bit 32 of the widened difference flags an address below the base.
  logic [32:0] offset;
  logic [31:0] region_idx;

  assign offset     = {1'b0, haddr_i} - {1'b0, BASE_ADDR};
  assign region_idx = offset[31:0] >> REGION_LOG2;

  // One-hot region hit; indices past the last slave fall through as unmapped.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    hit_o = '0;
    for (int n = 0; n < NUM_SLAVES; n++) begin
      hit_o[n] = !offset[32] && (region_idx == 32'(n));
    end
  end

  assign mapped_o = |hit_o;

endmodule

// File: rtl/ahb_apb_controller.sv
// AHB-Lite slave sequencer that turns accepted AHB transfers into APB
// setup/enable cycles, inserting wait states and a two-cycle ERROR response
// for unmapped addresses. hresetn is active-high despite its name.
module ahb_apb_controller
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          REGION_LOG2 = DEFAULT_REGION_LOG2
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  ahb_apb_controller_if.slave  bus
);

  state_e state_q, state_d, dispatch_next;

  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic                  write_q;

  logic [NUM_SLAVES-1:0] hit;
  logic                  mapped;
  logic                  acc;
  logic                  capture_en;

  logic                  pwrite, penable, hreadyout;
  logic [NUM_SLAVES-1:0] pselx;
  logic [31:0]           paddr, pwdata, hrdata;
  logic [1:0]            hresp;

  ahb_apb_decode #(
    .BASE_ADDR   (BASE_ADDR),
    .REGION_LOG2 (REGION_LOG2)
  ) u_decode (
    .haddr_i  (bus.haddr),
    .hit_o    (hit),
    .mapped_o (mapped)
  );

  assign acc = bus.hreadyin && is_active_trans(bus.htrans);
  // Address phases only land while hreadyout is high; elsewhere the master holds them.
  assign capture_en = acc && is_dispatch(state_q);

  // State register; reset drops straight to IDLE, abandoning any APB cycle.
  always_ff @(posedge hclk or posedge hresetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (hresetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Address-phase and write-data capture registers.
  always_ff @(posedge hclk or posedge hresetn) begin
    // NOTE: data registers are cleared too, because they feed pwdata/paddr directly.
    if (hresetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
    end else begin
      if (capture_en) begin
        addr_q  <= bus.haddr;
        write_q <= bus.hwrite;
        sel_q   <= hit;
      end
      if (state_q == ST_WWAIT) wdata_q <= bus.hwdata;
    end
  end

  // Successor of any state that can accept a new address phase.
  always_comb begin
    dispatch_next = ST_IDLE;
    if (acc) begin
      if (!mapped)         dispatch_next = ST_ERR1;
      else if (bus.hwrite) dispatch_next = ST_WWAIT;
      else                 dispatch_next = ST_READ;
    end
  end

  // Next-state and output decode; APB outputs depend on registered values only.
  always_comb begin
    state_d   = state_q;
    pselx     = '0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    paddr     = '0;
    pwdata    = '0;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    hrdata    = '0;
    case (state_q)
      ST_IDLE: state_d = dispatch_next;
      ST_WWAIT: begin
        hreadyout = 1'b0;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        pselx     = sel_q;
        paddr     = addr_q;
        pwdata    = wdata_q;
        pwrite    = write_q;
        hreadyout = 1'b0;
        state_d   = ST_WENABLE;
      end
      ST_WENABLE: begin
        pselx   = sel_q;
        paddr   = addr_q;
        pwdata  = wdata_q;
        pwrite  = write_q;
        penable = 1'b1;
        state_d = dispatch_next;
      end
      ST_READ: begin
        pselx     = sel_q;
        paddr     = addr_q;
        pwrite    = write_q;
        hreadyout = 1'b0;
        state_d   = ST_RENABLE;
      end
      ST_RENABLE: begin
        pselx   = sel_q;
        paddr   = addr_q;
        pwrite  = write_q;
        penable = 1'b1;
        hrdata  = bus.prdata;
        state_d = dispatch_next;
      end
      ST_ERR1: begin
        hresp     = HRESP_ERROR;
        hreadyout = 1'b0;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp   = HRESP_ERROR;
        state_d = dispatch_next;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.pselx     = pselx;
  assign bus.penable   = penable;
  assign bus.pwrite    = pwrite;
  assign bus.paddr     = paddr;
  assign bus.pwdata    = pwdata;
  assign bus.hreadyout = hreadyout;
  assign bus.hresp     = hresp;
  assign bus.hrdata    = hrdata;

endmodule

// File: tb/tb_ahb_apb_controller.sv
// Directed bench for ahb_apb_controller: per-cycle expected outputs are queued
// as stimulus is driven and popped/compared mid-cycle.
module tb_ahb_apb_controller;
  import ahb_apb_pkg::*;

  logic hclk = 1'b0;
  logic hresetn;

  ahb_apb_controller_if bus ();

  ahb_apb_controller dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  always #5 hclk = ~hclk;

  typedef struct packed {
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic        chk_addr;
    logic        chk_wdata;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic exp_t idle_exp(input logic full);
    exp_t e;
    e = '0;
    e.hreadyout = 1'b1;
    e.hresp     = HRESP_OKAY;
    e.chk_addr  = full;
    e.chk_wdata = full;
    return e;
  endfunction

  function automatic exp_t wait_exp();
    exp_t e;
    e = idle_exp(1'b0);
    e.hreadyout = 1'b0;
    return e;
  endfunction

  function automatic exp_t err_exp(input logic ready);
    exp_t e;
    e = idle_exp(1'b0);
    e.hresp     = HRESP_ERROR;
    e.hreadyout = ready;
    return e;
  endfunction

  function automatic exp_t write_exp(input logic [2:0] sel, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic en);
    exp_t e;
    e = '0;
    e.pselx     = sel;
    e.penable   = en;
    e.pwrite    = 1'b1;
    e.paddr     = addr;
    e.pwdata    = wdata;
    e.hreadyout = en;
    e.chk_addr  = 1'b1;
    e.chk_wdata = 1'b1;
    return e;
  endfunction

  function automatic exp_t read_exp(input logic [2:0] sel, input logic [31:0] addr,
                                    input logic en, input logic [31:0] rdata);
    exp_t e;
    e = '0;
    e.pselx     = sel;
    e.penable   = en;
    e.pwrite    = 1'b0;
    e.paddr     = addr;
    e.hrdata    = rdata;
    e.hreadyout = en;
    e.chk_addr  = 1'b1;
    e.chk_wdata = 1'b0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_now();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".pselx"},     32'(bus.pselx),     32'(e.pselx));
      check({t, ".penable"},   32'(bus.penable),   32'(e.penable));
      check({t, ".hreadyout"}, 32'(bus.hreadyout), 32'(e.hreadyout));
      check({t, ".hresp"},     32'(bus.hresp),     32'(e.hresp));
      check({t, ".hrdata"},    bus.hrdata,         e.hrdata);
      if (e.chk_addr) begin
        check({t, ".paddr"},  bus.paddr,        e.paddr);
        check({t, ".pwrite"}, 32'(bus.pwrite),  32'(e.pwrite));
      end
      if (e.chk_wdata) check({t, ".pwdata"}, bus.pwdata, e.pwdata);
    end
  endtask

  task automatic sample();
    @(negedge hclk);
    compare_now();
  endtask

  task automatic advance();
    @(posedge hclk);
    #1;
  endtask

  task automatic cyc(input string tag, input exp_t e);
    push(tag, e);
    sample();
    advance();
  endtask

  task automatic addr_phase(input logic [1:0] trans, input logic wr,
                            input logic [31:0] addr, input logic ready);
    bus.htrans   = trans;
    bus.hwrite   = wr;
    bus.haddr    = addr;
    bus.hreadyin = ready;
  endtask

  task automatic bus_idle();
    addr_phase(HTRANS_IDLE, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    hresetn    = 1'b1;
    bus_idle();
    bus.hwdata = '0;
    bus.prdata = '0;
    repeat (2) @(posedge hclk);
    #1;

    // Reset state and release
    cyc("reset", idle_exp(1'b1));
    hresetn = 1'b0;
    cyc("post_reset", idle_exp(1'b1));

    // Single write: 4-cycle latency, hwdata captured in the wait cycle only
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h8000_0010, 1'b1);
    cyc("wr_t0", idle_exp(1'b0));
    bus_idle();
    bus.hwdata = 32'hDEAD_BEEF;
    cyc("wr_t1", wait_exp());
    bus.hwdata = 32'h0BAD_0BAD;
    cyc("wr_t2", write_exp(3'b001, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0));
    cyc("wr_t3", write_exp(3'b001, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1));
    cyc("wr_done", idle_exp(1'b0));

    // Single read: 3-cycle latency, hrdata gated outside the enable cycle
    bus.prdata = 32'h0000_005A;
    addr_phase(HTRANS_NONSEQ, 1'b0, 32'h8400_0004, 1'b1);
    cyc("rd_t0", idle_exp(1'b0));
    bus_idle();
    cyc("rd_t1", read_exp(3'b010, 32'h8400_0004, 1'b0, 32'h0));
    cyc("rd_t2", read_exp(3'b010, 32'h8400_0004, 1'b1, 32'h0000_005A));
    cyc("rd_done", idle_exp(1'b0));

    // Back-to-back: write -> read -> write with no idle gap
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h8800_0000, 1'b1);
    cyc("b2b_w_t0", idle_exp(1'b0));
    bus_idle();
    bus.hwdata = 32'h1234_5678;
    cyc("b2b_w_t1", wait_exp());
    cyc("b2b_w_t2", write_exp(3'b100, 32'h8800_0000, 32'h1234_5678, 1'b0));
    addr_phase(HTRANS_NONSEQ, 1'b0, 32'h8000_0020, 1'b1);
    cyc("b2b_w_t3", write_exp(3'b100, 32'h8800_0000, 32'h1234_5678, 1'b1));
    bus_idle();
    bus.prdata = 32'hCAFE_F00D;
    cyc("b2b_r_t1", read_exp(3'b001, 32'h8000_0020, 1'b0, 32'h0));
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h8400_0100, 1'b1);
    cyc("b2b_r_t2", read_exp(3'b001, 32'h8000_0020, 1'b1, 32'hCAFE_F00D));
    bus_idle();
    bus.hwdata = 32'h600D_F00D;
    cyc("b2b_w2_t1", wait_exp());
    cyc("b2b_w2_t2", write_exp(3'b010, 32'h8400_0100, 32'h600D_F00D, 1'b0));
    cyc("b2b_w2_t3", write_exp(3'b010, 32'h8400_0100, 32'h600D_F00D, 1'b1));
    cyc("b2b_done", idle_exp(1'b0));

    // Unmapped address: two-cycle ERROR, no select activity
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h9000_0000, 1'b1);
    cyc("err_t0", idle_exp(1'b0));
    bus_idle();
    cyc("err_t1", err_exp(1'b0));
    cyc("err_t2", err_exp(1'b1));
    cyc("err_done", idle_exp(1'b0));

    // Region edges: just past slave 2 errors, new phase accepted in ERR2,
    // last word of slave 2 maps, just below the base errors
    addr_phase(HTRANS_NONSEQ, 1'b0, 32'h8C00_0000, 1'b1);
    cyc("edge_hi_t0", idle_exp(1'b0));
    bus_idle();
    cyc("edge_hi_t1", err_exp(1'b0));
    addr_phase(HTRANS_NONSEQ, 1'b0, 32'h8BFF_FFFC, 1'b1);
    cyc("edge_hi_t2", err_exp(1'b1));
    bus_idle();
    bus.prdata = 32'h0000_0077;
    cyc("edge_s2_t1", read_exp(3'b100, 32'h8BFF_FFFC, 1'b0, 32'h0));
    addr_phase(HTRANS_SEQ, 1'b1, 32'h7FFF_FFFC, 1'b1);
    cyc("edge_s2_t2", read_exp(3'b100, 32'h8BFF_FFFC, 1'b1, 32'h0000_0077));
    bus_idle();
    cyc("edge_lo_t1", err_exp(1'b0));
    cyc("edge_lo_t2", err_exp(1'b1));
    cyc("edge_done", idle_exp(1'b0));

    // Ignored transfers: IDLE, BUSY and NONSEQ without hreadyin
    addr_phase(HTRANS_IDLE, 1'b1, 32'h8000_0000, 1'b1);
    cyc("ign_idle", idle_exp(1'b0));
    addr_phase(HTRANS_BUSY, 1'b0, 32'h8400_0000, 1'b1);
    cyc("ign_busy", idle_exp(1'b0));
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h8800_0000, 1'b0);
    cyc("ign_nrdy", idle_exp(1'b0));
    bus_idle();
    cyc("ign_after1", idle_exp(1'b0));
    cyc("ign_after2", idle_exp(1'b0));

    // SEQ is accepted like NONSEQ
    bus.prdata = 32'h0BB0_0BB0;
    addr_phase(HTRANS_SEQ, 1'b0, 32'h8000_0000, 1'b1);
    cyc("seq_t0", idle_exp(1'b0));
    bus_idle();
    cyc("seq_t1", read_exp(3'b001, 32'h8000_0000, 1'b0, 32'h0));
    cyc("seq_t2", read_exp(3'b001, 32'h8000_0000, 1'b1, 32'h0BB0_0BB0));
    cyc("seq_done", idle_exp(1'b0));

    // Reset during the write setup cycle: outputs clear at once, no enable after release
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h8000_0040, 1'b1);
    cyc("rstw_t0", idle_exp(1'b0));
    bus_idle();
    bus.hwdata = 32'hA5A5_A5A5;
    cyc("rstw_t1", wait_exp());
    push("rstw_t2", write_exp(3'b001, 32'h8000_0040, 32'hA5A5_A5A5, 1'b0));
    sample();
    #1 hresetn = 1'b1;
    #1;
    push("rstw_async", idle_exp(1'b1));
    compare_now();
    advance();
    cyc("rstw_hold", idle_exp(1'b1));
    hresetn = 1'b0;
    cyc("rstw_rel1", idle_exp(1'b1));
    cyc("rstw_rel2", idle_exp(1'b1));
    cyc("rstw_rel3", idle_exp(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
